// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the instruction fetch slice.
//   XLEN      : datapath / address width
//   INSTR_NOP : canonical NOP (addi x0,x0,0), the value the output register holds after reset
//   RESET_PC  : default program counter after reset
//   fetch_state_e : fetch FSM states (IDLE, RUN, FAULT)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch -> decode valid/ready handshake.
//   if_valid : output register holds a valid instruction (fetch drives)
//   if_ready : decode accepts this cycle (decode drives)
//   if_instr : fetched instruction word
//   if_pc    : byte address of if_instr
// Modports: master = fetch unit, slave = decode.
interface instr_fetch_if;

  logic                      if_valid;
  logic                      if_ready;
  logic [riscv_pkg::XLEN-1:0] if_instr;
  logic [riscv_pkg::XLEN-1:0] if_pc;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);

endinterface

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: instruction/PC/valid holding register between fetch and decode.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture din_instr/din_pc and mark valid
//   flush      : drop the held instruction (wins over load)
//   ready      : decode accepted; clears valid when nothing new is loaded
//   valid, instr, pc : registered outputs
// With neither load, flush nor ready the contents hold, which keeps instr/pc
// stable while decode back-pressures.
module fetch_out_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [XLEN-1:0] din_instr,
  input  logic [XLEN-1:0] din_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= INSTR_NOP;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= din_instr;
      pc    <= din_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: initiator side of the instruction-memory read port.
//   clk, reset      : clock, asynchronous active-high reset
//   fetch_en        : permit issuing new fetches
//   imem_addr       : byte address to memory (always the current pc)
//   imem_instr      : combinational memory response for imem_addr
//   redirect_valid  : load redirect_pc as the next fetch pc and flush the output
//   redirect_pc     : redirect target byte address
//   dec             : valid/ready output to decode (instr_fetch_if.master)
//   fetch_fault     : sticky misaligned-redirect flag
// Build option: define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects
// into FAULT (exit only by reset). Otherwise the target's low two bits are
// cleared and fetch_fault is constant 0.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic [XLEN-1:0]       imem_addr,
  input  logic [XLEN-1:0]       imem_instr,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  instr_fetch_if.master         dec,
  output logic                  fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load, flush, slot_free, misaligned;

  assign imem_addr = pc_q;
  // if_ready only reaches pc via the registered decision below, never imem_addr directly.
  assign slot_free = !dec.if_valid || dec.if_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  // FAULT is left only by reset, so being in it is the sticky flag.
  assign fetch_fault = (state_q == FAULT);
`else
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (state_q != FAULT) begin
      // Capture in the same cycle fetch_en is seen so the first if_valid
      // appears one cycle after fetch_en rises; dropping fetch_en stops
      // captures immediately.
      state_d = fetch_en ? RUN : IDLE;
      if (redirect_valid) begin
        // Redirect beats capture and any concurrent handshake.
        flush = 1'b1;
        if (misaligned) state_d = FAULT;
        else            pc_d    = redirect_pc & ~XLEN'(3);
      end else if (fetch_en && slot_free) begin
        load = 1'b1;
        pc_d = pc_q + XLEN'(4);
      end
    end
  end

  fetch_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .flush     (flush),
    .ready     (dec.if_ready),
    .din_instr (imem_instr),
    .din_pc    (pc_q),
    .valid     (dec.if_valid),
    .instr     (dec.if_instr),
    .pc        (dec.if_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. Instance a uses RESET_PC 0,
// instance b uses RESET_PC 32'hFFFF_FFFC to exercise pc wrap-around.
// Honours FETCH_MISALIGN_CHECK_EN the same way as the design.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  function automatic logic [31:0] exp_word(input int w);
    if (w == 0)      return 32'h0031_00B3;
    else if (w == 1) return 32'h0040_8133;
    else             return 32'hA000_0000 | 32'(w);
  endfunction

  // instance a
  instr_fetch_if ifa();
  logic        fe_a, rv_a, ff_a;
  logic [31:0] rpc_a, addr_a, ins_a;
  assign ins_a = mem[addr_a[9:2]];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .fetch_en(fe_a), .imem_addr(addr_a), .imem_instr(ins_a),
    .redirect_valid(rv_a), .redirect_pc(rpc_a), .dec(ifa), .fetch_fault(ff_a));

  // instance b
  instr_fetch_if ifb();
  logic        fe_b, ff_b;
  logic [31:0] addr_b, ins_b;
  assign ins_b = mem[addr_b[9:2]];

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset), .fetch_en(fe_b), .imem_addr(addr_b), .imem_instr(ins_b),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .dec(ifb), .fetch_fault(ff_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    check({tag, " valid"}, 32'(ifa.if_valid), 32'd1);
    check({tag, " pc"},    ifa.if_pc, pc);
    check({tag, " instr"}, ifa.if_instr, exp_word(int'(pc[9:2])));
    check({tag, " addr"},  addr_a, addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = exp_word(i);
    reset = 1'b1; fe_a = 1'b0; rv_a = 1'b0; rpc_a = '0; ifa.if_ready = 1'b0;
    fe_b = 1'b0; ifb.if_ready = 1'b1;
    #3;
    check("rst valid", 32'(ifa.if_valid), 32'd0);
    check("rst instr", ifa.if_instr, INSTR_NOP);
    check("rst pc",    ifa.if_pc, 32'h0);
    check("rst addr",  addr_a, 32'h0);
    check("rst fault", 32'(ff_a), 32'd0);
    check("rst addr b", addr_b, 32'hFFFF_FFFC);
    step();
    reset = 1'b0;

    // streaming, one per cycle
    fe_a = 1'b1; ifa.if_ready = 1'b1;
    step(); check_out("w0", 32'h0, 32'h4);
    step(); check_out("w1", 32'h4, 32'h8);
    step(); check_out("w2", 32'h8, 32'hC);

    // back-pressure for three cycles
    ifa.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_out("hold", 32'h8, 32'hC);
    end
    ifa.if_ready = 1'b1;
    step(); check_out("rel0", 32'hC, 32'h10);
    step(); check_out("rel1", 32'h10, 32'h14);

    // redirect together with if_ready: current output discarded
    rv_a = 1'b1; rpc_a = 32'h40;
    step();
    check("redir valid", 32'(ifa.if_valid), 32'd0);
    check("redir addr",  addr_a, 32'h40);
    rv_a = 1'b0;
    step(); check_out("redir out", 32'h40, 32'h44);

    // drop fetch_en with pending instruction under back-pressure
    ifa.if_ready = 1'b0; fe_a = 1'b0;
    step(); check_out("idle hold0", 32'h40, 32'h44);
    step(); check_out("idle hold1", 32'h40, 32'h44);
    ifa.if_ready = 1'b1;
    step();
    check("idle drain valid", 32'(ifa.if_valid), 32'd0);
    check("idle drain addr",  addr_a, 32'h44);
    step();
    check("idle still valid", 32'(ifa.if_valid), 32'd0);
    fe_a = 1'b1;
    step(); check_out("resume0", 32'h44, 32'h48);
    step(); check_out("resume1", 32'h48, 32'h4C);

    // misaligned redirect
    rv_a = 1'b1; rpc_a = 32'h42;
    step();
    rv_a = 1'b0;
    check("mis valid", 32'(ifa.if_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis fault", 32'(ff_a), 32'd1);
    check("mis addr",  addr_a, 32'h4C);
    step();
    check("mis valid1", 32'(ifa.if_valid), 32'd0);
    step();
    check("mis valid2", 32'(ifa.if_valid), 32'd0);
    check("mis fault2", 32'(ff_a), 32'd1);
`else
    check("mis fault", 32'(ff_a), 32'd0);
    check("mis addr",  addr_a, 32'h40);
    step(); check_out("mis out", 32'h40, 32'h44);
`endif

    // asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    check("arst valid", 32'(ifa.if_valid), 32'd0);
    check("arst instr", ifa.if_instr, INSTR_NOP);
    check("arst pc",    ifa.if_pc, 32'h0);
    check("arst addr",  addr_a, 32'h0);
    check("arst fault", 32'(ff_a), 32'd0);
    step();
    reset = 1'b0;

    // wrap-around from RESET_PC 0xFFFF_FFFC
    fe_b = 1'b1;
    step();
    check("wrap valid0", 32'(ifb.if_valid), 32'd1);
    check("wrap pc0",    ifb.if_pc, 32'hFFFF_FFFC);
    check("wrap instr0", ifb.if_instr, exp_word(255));
    check("wrap addr",   addr_b, 32'h0);
    step();
    check("wrap pc1",    ifb.if_pc, 32'h0);
    check("wrap instr1", ifb.if_instr, exp_word(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction-memory read port. Holds the program counter, drives a word address to the combinational instruction memory every cycle, and captures the returned instruction with its PC into an output register offered to decode over a valid/ready handshake. Accepts redirects (branch/jump targets) from execute and honours downstream back-pressure without dropping or duplicating instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  1 = fetching permitted; 0 = stop issuing new fetches
- imem_addr  out  32  byte address to instruction memory (memory uses addr[9:2])
- imem_instr  in  32  instruction word, combinational response to imem_addr in the same cycle
- redirect_valid  in  1  load redirect_pc as next fetch PC, flush output register
- redirect_pc  in  32  redirect target byte address
- if_valid  out  1  output register holds a valid instruction
- if_ready  in  1  decode accepts this cycle
- if_instr  out  32  fetched instruction
- if_pc  out  32  byte address of if_instr
- fetch_fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, if_valid = 0, if_instr = 32'h0000_0013 (NOP), if_pc = 0, fetch_fault = 0, state = IDLE.
- imem_addr = pc continuously.
- States: IDLE, RUN, FAULT.
  - IDLE -> RUN when fetch_en = 1; RUN -> IDLE when fetch_en = 0 (no capture that cycle). FAULT exits only on reset.
- Slot free = !if_valid || if_ready.
- RUN, slot free, no redirect: capture if_instr <= imem_instr, if_pc <= pc, if_valid <= 1, pc <= pc + 4.
- RUN, slot not free: pc and output register hold; imem_addr stays on same PC.
- Handshake completes when if_valid && if_ready; in IDLE that clears if_valid, no refill.
- if_instr/if_pc stable while if_valid && !if_ready.
- redirect_valid (any state except FAULT) has priority over capture and handshake: if_valid <= 0, pc <= redirect_pc, no capture that cycle. Simultaneous if_ready is ignored (instruction discarded).
- redirect in IDLE updates pc; no fetch until fetch_en.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset mid-stream: all state returns to reset values immediately (asynchronous); in-flight output discarded.

## Timing
- Throughput: one instruction per cycle while if_ready = 1.
- Fetch latency: PC on imem_addr in cycle N -> if_valid with that instruction from edge ending N.
- fetch_en rise in cycle N (from reset/IDLE) -> first if_valid at cycle N+1.
- Redirect asserted cycle N -> imem_addr = target in N+1 -> if_valid, if_pc = target in N+2.
- if_ready is sampled only on rising edge; no combinational path from if_ready to imem_addr other than through pc.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 -> if_valid <= 0, fetch_fault <= 1, state -> FAULT; pc not updated; no further fetches until reset.
- Not defined: redirect_pc[1:0] forced to 2'b00 on load; fetch_fault tied 0; FAULT state unreachable.

## Structure
- Shared package riscv_pkg: XLEN = 32, INSTR_NOP = 32'h0000_0013, default RESET_PC, fetch state enum (IDLE, RUN, FAULT).
- One natural sub-module: fetch_out_reg (instr/pc/valid holding register with load, hold, flush controls); PC and FSM stay in instr_fetch.

## Test plan
- Reset, fetch_en = 1, if_ready = 1, memory word0 = 32'h0031_00B3, word1 = 32'h0040_8133 -> if_pc 0x0 then 0x4, if_instr matches, one per cycle.
- if_ready low 3 cycles with if_valid = 1 at pc 0x8 -> if_instr/if_pc held, imem_addr stays 0xC; on release 0x8 then 0xC delivered, none skipped or repeated.
- redirect_valid with redirect_pc = 0x40 in same cycle as if_ready = 1 -> current output discarded, if_valid 0 next cycle, if_pc = 0x40 two cycles after redirect.
- fetch_en dropped mid-stream -> pending instruction still handshaken, no new captures; re-raise resumes at next sequential PC.
- RESET_PC = 32'hFFFF_FFFC -> first if_pc 0xFFFF_FFFC, next 0x0000_0000.
- redirect_pc = 0x42: with FETCH_MISALIGN_CHECK_EN fetch_fault = 1, if_valid stays 0 until reset; without, next if_pc = 0x40.
